// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch producer for the IF/ID pipeline register.
// Owns the PC, issues at most one outstanding read to instruction memory, and
// holds the returned word with its PC in a single-entry buffer until the
// hazard unit consumes it. Redirects retarget the PC and discard any fetch
// that is still in flight.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_id_write         buffer consumed this cycle (from hazard unit)
//   redirect_valid/pc   taken branch/jump/flush and its target (word aligned here)
//   imem_req/addr       read request and address (combinational, addr = pc)
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/rdata   read response
//   if_valid/pc/instruction  buffered instruction presented to IF/ID
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_id_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redir_target;
    logic        fill;

    assign redir_target = redirect_pc & 32'hFFFF_FFFC;

    // Only request when the buffer will be free by the time the response
    // lands, so a response never has to wait for buffer space.
    assign imem_req  = (state == REQ) && !redirect_valid && (!if_valid || if_id_write);
    assign imem_addr = pc;

    // A response that coincides with a redirect is wrong-path and dropped.
    assign fill = (state == WAIT) && imem_rvalid && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            if_valid       <= 1'b0;
            if_pc          <= 32'h0;
            if_instruction <= 32'h0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (redirect_valid)
                        pc <= redir_target;
                    else if (imem_req && imem_ready)
                        state <= WAIT;
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc    <= redir_target;
                        // Without the response yet, the in-flight read must
                        // still be drained before the next request.
                        state <= imem_rvalid ? REQ : DROP;
                    end else if (imem_rvalid) begin
                        pc    <= pc + 32'(PC_STEP);
                        state <= REQ;
                    end
                end
                DROP: begin
                    if (redirect_valid)
                        pc <= redir_target;
                    if (imem_rvalid)
                        state <= REQ;
                end
                default: state <= IDLE;
            endcase

            if (fill) begin
                if_valid       <= 1'b1;
                if_pc          <= pc;
                if_instruction <= imem_rdata;
            end else if (redirect_valid && state != IDLE) begin
                if_valid <= 1'b0;
            end else if (if_id_write) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A second instance with RESET_PC at the top
// of the address space runs alongside the main one to cover PC wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_id_write, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc, if_instruction;

    logic        w_write, w_redir, w_ready, w_rvalid;
    logic [31:0] w_redir_pc, w_rdata;
    logic        w_req, w_if_valid;
    logic [31:0] w_addr, w_if_pc, w_if_instr;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int pend   = 0;
    logic [31:0] paddr = 32'h0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .if_id_write(if_id_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
        .clk(clk), .rst(rst), .if_id_write(w_write),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instruction(w_if_instr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock. Memory model: response arrives `lat` cycles after
    // acceptance as a one-cycle pulse, data = 0xD0000000 | addr. The wrap
    // instance gets a fixed 1-cycle memory with data = 0xE0000000 ^ addr.
    task automatic tick();
        logic acc, wacc;
        logic [31:0] aa, wa;
        acc  = imem_req && imem_ready;
        aa   = imem_addr;
        wacc = w_req && w_ready;
        wa   = w_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (acc) begin
            pend  = lat;
            paddr = aa;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hD000_0000 | paddr;
            end
        end
        w_rvalid = wacc;
        w_rdata  = 32'hE000_0000 ^ wa;
    endtask

    initial begin
        rst = 1'b1; if_id_write = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        w_write = 1'b1; w_redir = 1'b0; w_redir_pc = 32'h0; w_ready = 1'b1;
        w_rvalid = 1'b0; w_rdata = 32'h0;

        // 1. reset, then free run
        tick();
        rst = 1'b0; #1;
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instruction, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("idle_req", 32'(imem_req), 32'h0);
        tick();                                     // cycle 2: REQ
        chk("c2_req", 32'(imem_req), 32'h1);
        chk("c2_valid", 32'(if_valid), 32'h0);
        chk("w_first_addr", w_addr, 32'hFFFF_FFFC);
        tick();                                     // cycle 3: WAIT
        chk("c3_req", 32'(imem_req), 32'h0);
        chk("c3_valid", 32'(if_valid), 32'h0);
        tick();                                     // cycle 4: first valid
        chk("c4_valid", 32'(if_valid), 32'h1);
        chk("c4_pc", if_pc, 32'h0);
        chk("c4_instr", if_instruction, 32'hD000_0000);
        chk("c4_addr", imem_addr, 32'h4);
        chk("w_wrap_pc", w_if_pc, 32'hFFFF_FFFC);
        chk("w_wrap_instr", w_if_instr, 32'h1FFF_FFFC);
        chk("w_wrap_addr", w_addr, 32'h0);
        chk("w_wrap_req", 32'(w_req), 32'h1);
        tick();
        chk("c5_valid", 32'(if_valid), 32'h0);
        tick();
        chk("c6_pc", if_pc, 32'h4);
        chk("c6_instr", if_instruction, 32'hD000_0004);
        tick(); tick();
        chk("c8_valid", 32'(if_valid), 32'h1);
        chk("c8_pc", if_pc, 32'h8);

        // 2. stall with buffer full at PC 8
        if_id_write = 1'b0; #1;
        chk("stall_req0", 32'(imem_req), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req", 32'(imem_req), 32'h0);
            chk("stall_pc", if_pc, 32'h8);
            chk("stall_instr", if_instruction, 32'hD000_0008);
            chk("stall_valid", 32'(if_valid), 32'h1);
        end
        if_id_write = 1'b1; #1;
        chk("release_req", 32'(imem_req), 32'h1);
        chk("release_addr", imem_addr, 32'hC);
        tick();
        chk("release_consumed", 32'(if_valid), 32'h0);
        tick();
        chk("c_pc", if_pc, 32'hC);
        chk("c_instr", if_instruction, 32'hD000_000C);

        // 3. redirect in WAIT before the response arrives
        lat = 3;
        tick();                                     // accept 0x10
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();                                     // -> DROP
        redirect_valid = 1'b0; #1;
        chk("drop_req", 32'(imem_req), 32'h0);
        chk("drop_addr", imem_addr, 32'h100);
        chk("drop_valid", 32'(if_valid), 32'h0);
        tick();                                     // late data in DROP
        chk("drop_rvalid_valid", 32'(if_valid), 32'h0);
        chk("drop_rvalid_req", 32'(imem_req), 32'h0);
        tick();
        chk("post_drop_valid", 32'(if_valid), 32'h0);
        chk("post_drop_req", 32'(imem_req), 32'h1);
        chk("post_drop_addr", imem_addr, 32'h100);

        // 4. redirect coincident with rvalid, misaligned target
        lat = 1;
        tick();                                     // accept 0x100, rvalid now
        redirect_valid = 1'b1; redirect_pc = 32'h203; #1;
        chk("coinc_req", 32'(imem_req), 32'h0);
        tick();
        redirect_valid = 1'b0; #1;
        chk("coinc_valid", 32'(if_valid), 32'h0);
        chk("coinc_addr", imem_addr, 32'h200);
        chk("coinc_req2", 32'(imem_req), 32'h1);

        // 5a. redirects while draining; last one wins
        lat = 4;
        tick();                                     // accept 0x200
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();                                     // -> DROP
        redirect_pc = 32'h40;
        tick();
        redirect_pc = 32'h80;
        tick();                                     // rvalid now high in DROP
        redirect_valid = 1'b0; #1;
        chk("dd_addr", imem_addr, 32'h80);
        chk("dd_req", 32'(imem_req), 32'h0);
        tick();
        chk("dd_req2", 32'(imem_req), 32'h1);
        chk("dd_addr2", imem_addr, 32'h80);
        chk("dd_valid", 32'(if_valid), 32'h0);

        // 5b. reset during WAIT; stale response ignored
        lat = 2;
        tick();                                     // accept 0x80
        rst = 1'b1;
        tick();                                     // reset; stale rvalid now
        rst = 1'b0; #1;
        lat = 1;
        chk("mr_valid", 32'(if_valid), 32'h0);
        chk("mr_addr", imem_addr, 32'h0);
        chk("mr_req", 32'(imem_req), 32'h0);
        tick();
        chk("mr_stale_valid", 32'(if_valid), 32'h0);
        chk("mr_req2", 32'(imem_req), 32'h1);
        chk("mr_addr2", imem_addr, 32'h0);
        tick(); tick();
        chk("mr_fetch_valid", 32'(if_valid), 32'h1);
        chk("mr_fetch_pc", if_pc, 32'h0);
        chk("mr_fetch_instr", if_instruction, 32'hD000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
